// File: rtl/text_overlay_pkg.sv
// Shared types and constants for the text overlay controller.
// Cell geometry is fixed at 8x8 glyph pixels; only 5 columns come from the ROM.
package text_overlay_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ovl_state_e;

  localparam int CELL_W  = 8;
  localparam int CELL_H  = 8;
  localparam int GLYPH_W = 5;

  localparam logic [7:0] SPACE_CODE = 8'h20;

endpackage

// File: rtl/text_buffer_ram.sv
// Single-clock character buffer: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module text_buffer_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // No reset: contents are owned by the clear engine.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text window overlay: maps the VGA raster onto a character buffer, drives the
// glyph ROM and returns pixel_on two cycles after hc/vc. Also owns clear and cursor blink.
module text_overlay_ctrl
  import text_overlay_pkg::*;
#(
  parameter int COLS         = 32,
  parameter int ROWS         = 4,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int LOG2_SCALE   = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int AW           = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   hc,
  input  logic [10:0]   vc,
  input  logic          video_on,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  output logic          busy,
  input  logic          cursor_en,
  input  logic [AW-1:0] cursor_addr,
  output logic [7:0]    char_select,
  output logic [2:0]    char_x,
  output logic [2:0]    char_y,
  input  logic          rom_pixel,
  output logic          pixel_on
);

  localparam int DEPTH = COLS * ROWS;
  localparam int CW    = $clog2(COLS);
  localparam int SH    = $clog2(CELL_W) + LOG2_SCALE;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0] WIN_W = 12'((COLS * CELL_W) << LOG2_SCALE);
  localparam logic [11:0] WIN_H = 12'((ROWS * CELL_H) << LOG2_SCALE);

  // ---------------- S1 geometry (combinational) ----------------
  logic [11:0]   dx, dy;
  logic [10:0]   rel_x, rel_y, col_full, row_full;
  logic          in_win;
  logic [AW-1:0] rd_addr;
  logic [2:0]    gx, gy;

  // The borrow bit of the 12-bit subtraction flags hc < X0 / vc < Y0.
  assign dx       = {1'b0, hc} - 12'(X0);
  assign dy       = {1'b0, vc} - 12'(Y0);
  assign rel_x    = dx[10:0];
  assign rel_y    = dy[10:0];
  assign in_win   = video_on && !dx[11] && !dy[11] &&
                    ({1'b0, rel_x} < WIN_W) && ({1'b0, rel_y} < WIN_H);
  assign col_full = rel_x >> SH;
  assign row_full = rel_y >> SH;
  assign rd_addr  = AW'((row_full << CW) | col_full);
  assign gx       = rel_x[LOG2_SCALE +: 3];
  assign gy       = rel_y[LOG2_SCALE +: 3];

  // ---------------- S1 registers ----------------
  logic       in_win_q, cur_match_q, rd_ok_q, pixel_on_q;
  logic [2:0] gx_q, gy_q;
  logic [7:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_win_q    <= 1'b0;
      cur_match_q <= 1'b0;
      rd_ok_q     <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
    end else begin
      in_win_q    <= in_win;
      cur_match_q <= (rd_addr == cursor_addr);
      rd_ok_q     <= 1'b1;
      gx_q        <= gx;
      gy_q        <= gy;
    end
  end

  // ---------------- Clear FSM and buffer write port ----------------
  ovl_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Host writes only reach the RAM while idle; during a clear they are dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q;
      ram_wdata = SPACE_CODE;
    end else if (wr_en) begin
      ram_we = 1'b1;
    end
  end

  assign busy = busy_q;

  text_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_buf (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // ---------------- Cursor blink ----------------
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- S2: ROM drive and pixel register ----------------
  logic glyph_col, cursor_hit;

  assign glyph_col   = (gx_q < 3'(GLYPH_W));
  assign cursor_hit  = cursor_en && cur_match_q && blink_phase_q;
  // Before the first post-reset read the RAM output is undefined; show a space.
  assign char_select = rd_ok_q ? rd_data : SPACE_CODE;
  assign char_x      = glyph_col ? gx_q : 3'd0;
  assign char_y      = gy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_on_q <= 1'b0;
    end else begin
      pixel_on_q <= in_win_q && glyph_col && (rom_pixel ^ cursor_hit);
    end
  end

  assign pixel_on = pixel_on_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Scoreboard bench for text_overlay_ctrl: a tiny glyph ROM model feeds rom_pixel,
// the driver pushes expected pixel/char codes, a negedge monitor pops and compares.
module tb_text_overlay_ctrl;

  localparam int N = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc, vc;
  logic        video_on, frame_start, wr_en, clr, busy, cursor_en;
  logic [6:0]  wr_addr, cursor_addr;
  logic [7:0]  wr_data, char_select;
  logic [2:0]  char_x, char_y;
  logic        rom_pixel, pixel_on;

  always #5 clk = ~clk;

  text_overlay_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .hc          (hc),
    .vc          (vc),
    .video_on    (video_on),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr         (clr),
    .busy        (busy),
    .cursor_en   (cursor_en),
    .cursor_addr (cursor_addr),
    .char_select (char_select),
    .char_x      (char_x),
    .char_y      (char_y),
    .rom_pixel   (rom_pixel),
    .pixel_on    (pixel_on)
  );

  // Glyphs: 'T' = top bar + centre stem, 'A' = arch with crossbar, all else blank.
  function automatic logic glyph(input logic [7:0] c, input int x, input int y);
    if (x > 4 || y > 6) return 1'b0;
    case (c)
      8'h54:   return (y == 0) || (x == 2);
      8'h41:   return (y == 0 && x >= 1 && x <= 3) || (y >= 1 && (x == 0 || x == 4)) || (y == 3);
      default: return 1'b0;
    endcase
  endfunction

  assign rom_pixel = glyph(char_select, int'(char_x), int'(char_y));

  // ---------------- reference model state ----------------
  logic [7:0] mdl [N];
  logic       m_cur_en, m_phase;
  int         m_cur_addr, m_bcnt;

  function automatic logic in_window(input int h, input int v, input logic vo);
    return vo && h < 512 && v < 64;
  endfunction

  function automatic int cell_of(input int h, input int v);
    return (v >> 4) * 32 + (h >> 4);
  endfunction

  function automatic logic exp_pix(input int h, input int v, input logic vo);
    int gx, gy, a;
    if (!in_window(h, v, vo)) return 1'b0;
    gx = (h >> 1) % 8;
    gy = (v >> 1) % 8;
    a  = cell_of(h, v);
    if (gx >= 5) return 1'b0;
    return glyph(mdl[a], gx, gy) ^ (m_cur_en && a == m_cur_addr && m_phase);
  endfunction

  // ---------------- scoreboard ----------------
  logic       exp_q [$];
  logic [8:0] cs_q  [$];
  int         errors = 0;
  int         checks = 0;
  logic       pv;
  logic [1:0] vp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) vp <= 2'b00;
    else     vp <= {vp[0], pv};
  end

  always @(negedge clk) begin : monitor
    logic [8:0] e;
    logic       p;
    if (vp[0]) begin
      if (cs_q.size() == 0) check("cs_queue_underflow", 1, 0);
      else begin
        e = cs_q.pop_front();
        if (e[8]) check("char_select", int'(char_select), int'(e[7:0]));
      end
    end
    if (vp[1]) begin
      if (exp_q.size() == 0) check("pix_queue_underflow", 1, 0);
      else begin
        p = exp_q.pop_front();
        check("pixel_on", int'(pixel_on), int'(p));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_px(input int h, input int v, input logic vo);
    hc       = 11'(h);
    vc       = 11'(v);
    video_on = vo;
    pv       = 1'b1;
    exp_q.push_back(exp_pix(h, v, vo));
    if (in_window(h, v, vo)) cs_q.push_back({1'b1, mdl[cell_of(h, v)]});
    else                     cs_q.push_back(9'h000);
    @(posedge clk); #1;
  endtask

  task automatic px_idle();
    pv       = 1'b0;
    video_on = 1'b0;
    hc       = '0;
    vc       = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 7'(a);
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    mdl[a]  = d;
  endtask

  task automatic pulse_frames(input int k);
    for (int i = 0; i < k; i++) begin
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(posedge clk); #1;
      m_bcnt++;
      if (m_bcnt == 30) begin
        m_bcnt  = 0;
        m_phase = ~m_phase;
      end
    end
  endtask

  // Counts cycles with busy high, bounded so a stuck busy still ends the run.
  task automatic count_busy(output int n);
    int guard;
    n     = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 1000) begin
      n++;
      guard++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    rst = 1'b1; hc = '0; vc = '0; video_on = 1'b0; frame_start = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    cursor_en = 1'b0; cursor_addr = '0; pv = 1'b0;
    m_cur_en = 1'b0; m_cur_addr = 0; m_phase = 1'b0; m_bcnt = 0;
    for (int i = 0; i < N; i++) mdl[i] = 8'h20;

    repeat (2) @(posedge clk);
    #1;
    check("reset_pixel_on", int'(pixel_on), 0);
    check("reset_char_select", int'(char_select), 8'h20);
    check("reset_char_x", int'(char_x), 0);
    check("reset_char_y", int'(char_y), 0);
    check("reset_busy", int'(busy), 1);

    rst = 1'b0;
    count_busy(n);
    check("busy_cycles_after_reset", n, 128);
    check("busy_low_after_clear", int'(busy), 0);

    // Whole window, every other pixel: all spaces, nothing lit.
    for (int r = 0; r < 4; r++)
      for (int gy = 0; gy < 8; gy++)
        for (int h = 0; h < 512; h += 2)
          drive_px(h, r * 16 + gy * 2, 1'b1);
    px_idle();

    // 'T' at cell 0, top glyph row.
    write_cell(0, 8'h54);
    for (int h = 0; h < 16; h++) drive_px(h, 0, 1'b1);
    // Stem column on glyph rows 1 and 6.
    for (int h = 0; h < 16; h++) drive_px(h, 2, 1'b1);
    for (int h = 0; h < 16; h++) drive_px(h, 12, 1'b1);
    px_idle();

    // Outside the window or blanked.
    drive_px(0, 64, 1'b1);
    drive_px(512, 0, 1'b1);
    drive_px(2, 0, 1'b0);
    drive_px(4, 1, 1'b0);
    drive_px(511, 63, 1'b1);
    drive_px(0, 0, 1'b1);
    px_idle();

    // Cursor on space cell 5: blink phase on after 30 frames, off after 30 more.
    cursor_en = 1'b1; cursor_addr = 7'd5;
    m_cur_en  = 1'b1; m_cur_addr  = 5;
    pulse_frames(30);
    for (int h = 64; h < 96; h++) drive_px(h, 0, 1'b1);
    for (int h = 80; h < 96; h++) drive_px(h, 14, 1'b1);
    px_idle();
    pulse_frames(30);
    for (int h = 80; h < 96; h++) drive_px(h, 0, 1'b1);
    px_idle();
    cursor_en = 1'b0;
    m_cur_en  = 1'b0;

    // Clear with a write issued one cycle later: the write is dropped.
    write_cell(3, 8'h54);
    for (int h = 48; h < 58; h++) drive_px(h, 0, 1'b1);
    px_idle();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    wr_en = 1'b1; wr_addr = 7'd3; wr_data = 8'h41;
    fork
      begin
        @(posedge clk); #1;
        wr_en = 1'b0;
      end
    join_none
    count_busy(n);
    check("busy_cycles_clr", n, 128);
    for (int i = 0; i < N; i++) mdl[i] = 8'h20;
    for (int h = 48; h < 58; h++) drive_px(h, 0, 1'b1);
    for (int h = 48; h < 58; h++) drive_px(h, 6, 1'b1);
    for (int h = 0; h < 10; h++) drive_px(h, 0, 1'b1);
    px_idle();

    // Reset 50 cycles into a clear restarts it from zero.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("busy_mid_clear", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("busy_in_reset", int'(busy), 1);
    check("char_select_in_reset", int'(char_select), 8'h20);
    @(posedge clk); #1;
    rst = 1'b0;
    m_phase = 1'b0;
    m_bcnt  = 0;
    count_busy(n);
    check("busy_cycles_after_mid_reset", n, 128);

    // Write and display-read of cell 7 in the same cycle: old code shown once.
    wr_en = 1'b1; wr_addr = 7'd7; wr_data = 8'h54;
    drive_px(116, 0, 1'b1);
    wr_en  = 1'b0;
    mdl[7] = 8'h54;
    drive_px(116, 0, 1'b1);
    drive_px(116, 2, 1'b1);
    drive_px(112, 2, 1'b1);
    px_idle();

    check("scoreboard_drained", exp_q.size() + cs_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/text_overlay_ctrl.md
Name: text_overlay_ctrl

Overview:
- Sequences the 5x8 character-glyph ROM (`characters`) to draw a COLS x ROWS text window on the VGA raster.
- Holds a text buffer of character codes with a host write port, a clear engine and a blinking cursor.
- Converts the VGA counters (hc, vc) into buffer address, glyph column and glyph row, drives the ROM, and returns a pixel-aligned `pixel_on` to the colour mixer.

Parameters:
- COLS, 32, characters per text row; power of two.
- ROWS, 4, text rows.
- X0, 0, screen x of window left edge.
- Y0, 0, screen y of window top edge.
- LOG2_SCALE, 1, each glyph pixel is 2^LOG2_SCALE x 2^LOG2_SCALE screen pixels.
- BLINK_FRAMES, 30, frames per cursor blink half-period.
- AW, $clog2(COLS*ROWS), buffer address width (derived).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hc  in  11  horizontal pixel counter
- vc  in  11  vertical line counter
- video_on  in  1  hc/vc inside visible area
- frame_start  in  1  one-cycle pulse per frame
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  write address, row*COLS+col
- wr_data  in  8  ASCII code
- clr  in  1  pulse: fill buffer with 8'h20
- busy  out  1  clear in progress
- cursor_en  in  1  enable cursor
- cursor_addr  in  AW  cursor cell
- char_select  out  8  to ROM select
- char_x  out  3  to ROM coor_x
- char_y  out  3  to ROM coor_y
- rom_pixel  in  1  ROM pixel (combinational from char_select/char_x/char_y)
- pixel_on  out  1  text pixel lit

Behaviour:
- Reset values:
  - pixel_on=0, char_select=8'h20, char_x=0, char_y=0.
  - busy=1; FSM=CLEAR, clear pointer=0.
  - blink counter=0, blink phase=0.
- Geometry:
  - rel_x = hc - X0; rel_y = vc - Y0, both 11-bit.
  - Cell is 8x8 glyph pixels: glyph columns 0..4 come from the ROM, columns 5..7 are spacing.
  - in_win = video_on & hc>=X0 & vc>=Y0 & rel_x < COLS*8<<LOG2_SCALE & rel_y < ROWS*8<<LOG2_SCALE.
  - col = rel_x>>(3+LOG2_SCALE); row = rel_y>>(3+LOG2_SCALE); addr = {row,col}.
  - gx = (rel_x>>LOG2_SCALE)[2:0]; gy = (rel_y>>LOG2_SCALE)[2:0].
  - No dividers.
- Pipeline (latency exactly 2 cycles from hc/vc to pixel_on):
  - S1: register in_win, gx, gy, addr==cursor_addr; synchronous buffer read of addr.
  - S2 comb: char_select = read data; char_x = gx when gx<5, else 0; char_y = gy.
  - S2 reg: pixel_on = S1 in_win & (gx<5) & (rom_pixel ^ cursor_hit).
  - cursor_hit = cursor_en & addr==cursor_addr & blink_phase.
  - pixel_on=0 outside the window and whenever !video_on.
- ROM orientation: char_y=0 is the top glyph row; char_x=0 is the leftmost column. Glyph row 7 is blank by font design.
- Buffer:
  - COLS*ROWS x 8 single-clock RAM; one write port, one synchronous read port.
  - Same-address read and write in one cycle: read returns old data.
  - No reset of the array; contents are defined only by the clear engine.
- FSM:
  - IDLE: wr_en writes wr_data to wr_addr; clr -> CLEAR with ptr=0, busy=1.
  - CLEAR: writes 8'h20 to ptr each cycle, ptr++; after ptr==COLS*ROWS-1 -> IDLE, busy=0 the next cycle.
  - A clear lasts exactly COLS*ROWS cycles.
  - wr_en and clr are ignored while busy (dropped, not queued).
  - rst mid-clear restarts the clear from 0.
  - Display reads continue during a clear and may show partially cleared text.
- Blink:
  - Counter increments on frame_start; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - cursor_en=0 does not stop the counter.
  - frame_start and other events never conflict; all are independent.

Decomposition:
- Package `text_overlay_pkg`:
  - typedef enum {IDLE, CLEAR} for the FSM state.
  - localparam CELL_W=8, CELL_H=8, GLYPH_W=5, SPACE_CODE=8'h20.
- Sub-module `text_buffer_ram`: parameterised depth; sync write, sync read-old-data; infers BRAM.
- Top instantiates `text_buffer_ram` only. `characters` is instantiated by the parent and connects through the char_*/rom_pixel ports.

Test Plan:
- Reset release with default params, no further input -> busy=1 for 128 cycles, then 0. Sweep the window afterwards -> pixel_on=0 everywhere, all cells = 8'h20.
- Write 'T' (8'h54) at addr 0; drive vc=0, hc=0..15 with video_on=1 -> pixel_on=1 for hc 0..9, 0 for hc 10..15. Each appears 2 cycles after its hc; char_select=8'h54.
- Drive vc=64 (row 4 is outside ROWS), then hc=512 on vc=0 -> pixel_on=0. Drive video_on=0 inside the window -> pixel_on=0.
- cursor_en=1, cursor_addr=5 on a space cell; pulse frame_start 30 times -> cell 5 glyph pixels (gx<5) read 1, spacing columns stay 0. Pulse 30 more -> back to 0.
- Pulse clr, then on the next cycle wr_en with addr 3, data 'A' -> write dropped, addr 3 reads 8'h20 after busy falls. Assert rst at clear cycle 50 -> busy stays 1 and completes 128 cycles after rst deasserts.
- Write addr 7 and display-read addr 7 in the same cycle -> that pixel uses the old code; the next line uses the new code.
